// File: rtl/bist_sequencer.sv
// BIST sequencer: applies generator patterns to a combinational CUT, compacts its
// response in an 8-bit SISR and compares it with a golden signature.
// Optional build macro BIST_EXHAUSTIVE_EN: exhaustive 4-bit up-counter generator (16 patterns).
module bist_sequencer #(
  parameter int          PAT_COUNT  = 15,
  parameter int          SETTLE     = 1,
  parameter logic [3:0]  SEED       = 4'b0001,
  parameter logic [7:0]  GOLDEN_SIG = 8'h00
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic       cut_out,
  output logic [3:0] cut_in,
  output logic       busy,
  output logic       done,
  output logic       pass,
  output logic [7:0] signature,
  output logic [4:0] pat_idx
);

  typedef enum logic [2:0] {
    st_idle    = 3'd0,
    st_init    = 3'd1,
    st_apply   = 3'd2,
    st_capture = 3'd3,
    st_compare = 3'd4,
    st_done    = 3'd5
  } state_t;

`ifdef BIST_EXHAUSTIVE_EN
  localparam logic [4:0] num_pat  = 5'd16;
  localparam logic [3:0] gen_init = 4'b0000;

  function automatic logic [3:0] gen_next(input logic [3:0] q);
    return q + 4'd1;
  endfunction
`else
  localparam logic [4:0] num_pat  = 5'(PAT_COUNT);
  // An all-zero seed would lock the LFSR, so it is replaced by 0001.
  localparam logic [3:0] gen_init = (SEED == 4'b0000) ? 4'b0001 : SEED;

  function automatic logic [3:0] gen_next(input logic [3:0] q);
    return {q[2:0], q[3] ^ q[2]};
  endfunction
`endif

  localparam logic [3:0] settle_last = 4'(SETTLE - 1);

  function automatic logic [7:0] sisr_next(input logic [7:0] s, input logic d);
    return {s[6:0], s[7] ^ d} ^ (s[7] ? 8'h1C : 8'h00);
  endfunction

  state_t     state_r;
  state_t     next_state_s;
  logic       load_s;
  logic       capture_s;
  logic       compare_s;
  logic       last_pat_s;
  logic       next_busy_s;
  logic [3:0] gen_r;
  logic [3:0] cut_in_r;
  logic [7:0] sisr_r;
  logic [4:0] pat_idx_r;
  logic [3:0] settle_cnt_r;
  logic       pass_r;
  logic       busy_r;
  logic       done_r;

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r <= st_idle;
    end else begin
      state_r <= next_state_s;
    end
  end

  // Next-state logic and per-state datapath strobes
  always_comb begin
    next_state_s = state_r;
    load_s       = 1'b0;
    capture_s    = 1'b0;
    compare_s    = 1'b0;
    last_pat_s   = ((pat_idx_r + 5'd1) == num_pat);
    case (state_r)
      st_idle: begin
        if (start) begin
          next_state_s = st_init;
        end else begin
          next_state_s = st_idle;
        end
      end
      st_init: begin
        load_s       = 1'b1;
        next_state_s = st_apply;
      end
      st_apply: begin
        if (settle_cnt_r == settle_last) begin
          next_state_s = st_capture;
        end else begin
          next_state_s = st_apply;
        end
      end
      st_capture: begin
        capture_s = 1'b1;
        if (last_pat_s) begin
          next_state_s = st_compare;
        end else begin
          next_state_s = st_apply;
        end
      end
      st_compare: begin
        compare_s    = 1'b1;
        next_state_s = st_done;
      end
      st_done: begin
        if (start) begin
          next_state_s = st_init;
        end else begin
          next_state_s = st_done;
        end
      end
      default: begin
        next_state_s = st_idle;
      end
    endcase
  end

  // Status flags are registered from the next state so they line up with state_r
  always_comb begin
    next_busy_s = 1'b0;
    case (next_state_s)
      st_init, st_apply, st_capture, st_compare: next_busy_s = 1'b1;
      default:                                   next_busy_s = 1'b0;
    endcase
  end

  // Generator, SISR, counters and result registers
  always_ff @(posedge clk) begin
    if (rst) begin
      gen_r        <= 4'b0000;
      cut_in_r     <= 4'b0000;
      sisr_r       <= 8'h00;
      pat_idx_r    <= 5'd0;
      settle_cnt_r <= 4'd0;
      pass_r       <= 1'b0;
      busy_r       <= 1'b0;
      done_r       <= 1'b0;
    end else begin
      busy_r <= next_busy_s;
      done_r <= (next_state_s == st_done);
      if (load_s) begin
        gen_r        <= gen_init;
        cut_in_r     <= gen_init;
        sisr_r       <= 8'h00;
        pat_idx_r    <= 5'd0;
        settle_cnt_r <= 4'd0;
        pass_r       <= 1'b0;
      end else if (capture_s) begin
        sisr_r       <= sisr_next(sisr_r, cut_out);
        pat_idx_r    <= pat_idx_r + 5'd1;
        gen_r        <= gen_next(gen_r);
        settle_cnt_r <= 4'd0;
        // The last applied pattern stays on the CUT through DONE.
        if (!last_pat_s) begin
          cut_in_r <= gen_next(gen_r);
        end else begin
          cut_in_r <= cut_in_r;
        end
      end else if (state_r == st_apply) begin
        settle_cnt_r <= settle_cnt_r + 4'd1;
      end else if (compare_s) begin
        pass_r <= (sisr_r == GOLDEN_SIG);
      end else begin
        settle_cnt_r <= settle_cnt_r;
      end
    end
  end

  assign cut_in    = cut_in_r;
  assign busy      = busy_r;
  assign done      = done_r;
  assign pass      = pass_r;
  assign signature = sisr_r;
  assign pat_idx   = pat_idx_r;

endmodule

// File: tb/tb_bist_sequencer.sv
// Directed self-checking bench for bist_sequencer: default instance plus a
// SETTLE=3 / PAT_COUNT=4 instance; expectations follow BIST_EXHAUSTIVE_EN when defined.
module tb_bist_sequencer;

  logic       clk;
  logic       rst;
  logic       start1, cut_out1;
  logic [3:0] cut_in1;
  logic       busy1, done1, pass1;
  logic [7:0] sig1;
  logic [4:0] pat_idx1;
  logic       start2, cut_out2;
  logic [3:0] cut_in2;
  logic       busy2, done2, pass2;
  logic [7:0] sig2;
  logic [4:0] pat_idx2;

  int tests_run  = 0;
  int tests_fail = 0;

`ifdef BIST_EXHAUSTIVE_EN
  localparam int         N1      = 16;
  localparam int         N2      = 16;
  localparam logic [7:0] SA1_SIG = 8'h3B;
`else
  localparam int         N1      = 15;
  localparam int         N2      = 4;
  localparam logic [7:0] SA1_SIG = 8'h1D;
`endif

  bist_sequencer dut1 (
    .clk(clk), .rst(rst), .start(start1), .cut_out(cut_out1), .cut_in(cut_in1),
    .busy(busy1), .done(done1), .pass(pass1), .signature(sig1), .pat_idx(pat_idx1)
  );

  bist_sequencer #(.SETTLE(3), .PAT_COUNT(4)) dut2 (
    .clk(clk), .rst(rst), .start(start2), .cut_out(cut_out2), .cut_in(cut_in2),
    .busy(busy2), .done(done2), .pass(pass2), .signature(sig2), .pat_idx(pat_idx2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests_run++;
    if (obs !== exp) begin
      tests_fail++;
      $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
    end
  endtask

  // Hand-derived pattern order from seed 0001 (or the counter value when exhaustive)
  function automatic logic [3:0] exp_pat(input int i);
`ifdef BIST_EXHAUSTIVE_EN
    return 4'(i);
`else
    case (i)
      0:  return 4'b0001;
      1:  return 4'b0010;
      2:  return 4'b0100;
      3:  return 4'b1001;
      4:  return 4'b0011;
      5:  return 4'b0110;
      6:  return 4'b1101;
      7:  return 4'b1010;
      8:  return 4'b0101;
      9:  return 4'b1011;
      10: return 4'b0111;
      11: return 4'b1111;
      12: return 4'b1110;
      13: return 4'b1100;
      14: return 4'b1000;
      default: return 4'b0000;
    endcase
`endif
  endfunction

  task automatic run1(input string tag, input logic co, input logic [7:0] exp_sig,
                      input logic exp_pass, input bit pulse_mid);
    int cyc;
    bit seen;
    cut_out1 = co;
    @(negedge clk); start1 = 1'b1;
    @(negedge clk); start1 = 1'b0;
    check({tag, "_init_busy"}, 32'(busy1), 32'd1);
    cyc  = 0;
    seen = 1'b0;
    while (cyc < 200 && !seen) begin
      if (pulse_mid && cyc == 10) start1 = 1'b1;
      else start1 = 1'b0;
      @(negedge clk);
      cyc++;
      if (done1) begin
        seen = 1'b1;
      end else if (((cyc - 1) % 2) == 0 && ((cyc - 1) / 2) < N1) begin
        check({tag, "_pat"}, 32'(cut_in1), 32'(exp_pat((cyc - 1) / 2)));
        check({tag, "_idx"}, 32'(pat_idx1), 32'((cyc - 1) / 2));
      end
    end
    start1 = 1'b0;
    check({tag, "_done_seen"}, 32'(seen), 32'd1);
    check({tag, "_len"}, 32'(cyc), 32'(1 + N1 * 2 + 1));
    check({tag, "_busy_low"}, 32'(busy1), 32'd0);
    check({tag, "_pass"}, 32'(pass1), 32'(exp_pass));
    check({tag, "_sig"}, 32'(sig1), 32'(exp_sig));
    check({tag, "_pat_idx"}, 32'(pat_idx1), 32'(N1));
    check({tag, "_last_pat"}, 32'(cut_in1), 32'(exp_pat(N1 - 1)));
    repeat (2) @(negedge clk);
    check({tag, "_hold_done"}, 32'(done1), 32'd1);
    check({tag, "_hold_sig"}, 32'(sig1), 32'(exp_sig));
    check({tag, "_hold_pat"}, 32'(cut_in1), 32'(exp_pat(N1 - 1)));
  endtask

  initial begin
    int cyc;
    bit seen;
    logic [7:0] sig_a;
    rst = 1'b1; start1 = 1'b0; cut_out1 = 1'b0; start2 = 1'b0; cut_out2 = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_cut_in", 32'(cut_in1), 32'd0);
    check("rst_busy", 32'(busy1), 32'd0);
    check("rst_done", 32'(done1), 32'd0);
    check("rst_pass", 32'(pass1), 32'd0);
    check("rst_sig", 32'(sig1), 32'd0);
    check("rst_idx", 32'(pat_idx1), 32'd0);
    check("rst_busy2", 32'(busy2), 32'd0);
    rst = 1'b0;
    repeat (2) @(negedge clk);
    check("idle_cut_in", 32'(cut_in1), 32'd0);

    // Fault-free run with a start pulse injected while busy
    run1("ff", 1'b0, 8'h00, 1'b1, 1'b1);
    // Stuck-at-1 response
    run1("sa1", 1'b1, SA1_SIG, 1'b0, 1'b0);

    // SETTLE=3, PAT_COUNT=4 instance
    @(negedge clk); start2 = 1'b1;
    @(negedge clk); start2 = 1'b0;
    cyc = 0; seen = 1'b0;
    while (cyc < 300 && !seen) begin
      @(negedge clk);
      cyc++;
      if (done2) seen = 1'b1;
      else if (cyc <= 4) begin
        check("s3_hold_pat0", 32'(cut_in2), 32'(exp_pat(0)));
        check("s3_hold_idx0", 32'(pat_idx2), 32'd0);
      end else if (cyc == 5) begin
        check("s3_pat1", 32'(cut_in2), 32'(exp_pat(1)));
        check("s3_idx1", 32'(pat_idx2), 32'd1);
      end
    end
    check("s3_done_seen", 32'(seen), 32'd1);
    check("s3_len", 32'(cyc), 32'(1 + N2 * 4 + 1));
    check("s3_pat_idx", 32'(pat_idx2), 32'(N2));
    check("s3_pass", 32'(pass2), 32'd1);
    check("s3_sig", 32'(sig2), 32'd0);
    check("s3_last_pat", 32'(cut_in2), 32'(exp_pat(N2 - 1)));

    // Reset in the middle of a run
    cut_out1 = 1'b1;
    @(negedge clk); start1 = 1'b1;
    @(negedge clk); start1 = 1'b0;
    cyc = 0;
    while (cyc < 100 && pat_idx1 != 5'd7) begin
      @(negedge clk);
      cyc++;
    end
    check("mid_reached_7", 32'(pat_idx1), 32'd7);
    check("mid_sig_nonzero", 32'(sig1 != 8'h00), 32'd1);
    rst = 1'b1;
    @(negedge clk);
    check("mid_rst_cut_in", 32'(cut_in1), 32'd0);
    check("mid_rst_busy", 32'(busy1), 32'd0);
    check("mid_rst_done", 32'(done1), 32'd0);
    check("mid_rst_pass", 32'(pass1), 32'd0);
    check("mid_rst_sig", 32'(sig1), 32'd0);
    check("mid_rst_idx", 32'(pat_idx1), 32'd0);
    rst = 1'b0;
    @(negedge clk);
    run1("after_rst", 1'b0, 8'h00, 1'b1, 1'b0);

    // start held high: back-to-back runs with identical signatures
    cut_out1 = 1'b1;
    @(negedge clk); start1 = 1'b1;
    @(negedge clk);
    cyc = 0;
    while (cyc < 200 && !done1) begin
      @(negedge clk);
      cyc++;
    end
    check("held_done1", 32'(done1), 32'd1);
    sig_a = sig1;
    check("held_sig1", 32'(sig_a), 32'(SA1_SIG));
    @(negedge clk);
    check("held_restart_busy", 32'(busy1), 32'd1);
    check("held_restart_done", 32'(done1), 32'd0);
    cyc = 0;
    while (cyc < 200 && !done1) begin
      @(negedge clk);
      cyc++;
    end
    check("held_done2", 32'(done1), 32'd1);
    check("held_len2", 32'(cyc), 32'(1 + N1 * 2 + 1));
    check("held_sig2", 32'(sig1), 32'(sig_a));
    start1 = 1'b0;
    repeat (2) @(negedge clk);
    check("held_stop_done", 32'(done1), 32'd1);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_fail);
    $finish;
  end

endmodule

// File: doc/bist_sequencer.md
BIST_SEQUENCER -- requirements
Module: bist_sequencer

Interface
REQ-001 The block SHALL provide parameter PAT_COUNT, default 15: number of LFSR patterns applied per run (legal 1..15).
REQ-002 The block SHALL provide parameter SETTLE, default 1: cycles each pattern is held before capture (legal 1..15).
REQ-003 The block SHALL provide parameter SEED, default 4'b0001: LFSR start value; a zero value is replaced by 4'b0001.
REQ-004 The block SHALL provide parameter GOLDEN_SIG, default 8'h00: expected fault-free signature.
REQ-005 Port clk, input, 1 bit: the single clock; every register updates on its rising edge.
REQ-006 Port rst, input, 1 bit: synchronous, active-high reset.
REQ-007 Port start, input, 1 bit: run request, sampled in IDLE or DONE only.
REQ-008 Port cut_out, input, 1 bit: response from the combinational circuit under test (CUT).
REQ-009 Port cut_in, output, 4 bits: registered pattern to the CUT; [3]=one, [2]=two, [1]=three, [0]=four.
REQ-010 Port busy, output, 1 bit: high in INIT, APPLY, CAPTURE and COMPARE.
REQ-011 Port done, output, 1 bit: high in DONE.
REQ-012 Port pass, output, 1 bit: compare result, valid while done=1.
REQ-013 Port signature, output, 8 bits: current SISR contents.
REQ-014 Port pat_idx, output, 5 bits: number of patterns captured so far in the current run.

Function
REQ-015 The FSM SHALL have the states IDLE, INIT, APPLY, CAPTURE, COMPARE and DONE.
REQ-016 IDLE/DONE: start=1 SHALL move to INIT; start is ignored in all other states.
REQ-017 INIT (1 cycle) SHALL load the generator with SEED, clear the SISR, pat_idx and the settle counter, then go to APPLY.
REQ-018 APPLY SHALL hold cut_in for SETTLE cycles, then go to CAPTURE.
REQ-019 CAPTURE (1 cycle) SHALL shift cut_out into the SISR, increment pat_idx and advance the generator. It then goes to COMPARE when pat_idx reaches the pattern count, otherwise back to APPLY.
REQ-020 The LFSR SHALL be Fibonacci, with next = {q[2:0], q[3]^q[2]} (period 15). From seed 0001 it SHALL produce 0001, 0010, 0100, 1001, 0011, ...
REQ-021 The SISR SHALL be 8-bit, polynomial x^8+x^4+x^3+x^2+1, with next = {s[6:0], s[7]^cut_out} XOR (s[7] ? 8'h1C : 8'h00).
REQ-022 COMPARE (1 cycle) SHALL register pass = (signature == GOLDEN_SIG), then go to DONE.
REQ-023 DONE SHALL hold pass, signature and cut_in (last applied pattern) until the next start.
REQ-024 Run length SHALL be 1 + N*(SETTLE+1) + 1 cycles from the INIT entry to the DONE entry, where N is the pattern count.
REQ-025 While the block is in IDLE, cut_in SHALL be 4'b0000.
REQ-026 start held continuously SHALL restart a new run on the cycle after DONE is entered.

Reset
REQ-027 When rst=1 at a clock edge, the next state SHALL be IDLE with cut_in=0, busy=0, done=0, pass=0, signature=8'h00 and pat_idx=0.
REQ-028 rst SHALL take priority over start and over any in-progress run; there SHALL be no partial-run state after reset.

Configuration
REQ-029 With BIST_EXHAUSTIVE_EN defined, the generator SHALL be a 4-bit up-counter starting at 0000, the pattern count SHALL be fixed at 16, SEED and PAT_COUNT SHALL be unused, and pat_idx SHALL reach 16.
REQ-030 Without BIST_EXHAUSTIVE_EN, the LFSR generator of REQ-020 SHALL be used with PAT_COUNT patterns.

Verification
REQ-031 Defaults, fault-free CUT (cut_out always 0), pulse start -> cut_in sequence 0001, 0010, 0100, 1001, ...; done at cycle 32 after INIT entry; signature 8'h00; pass=1.
REQ-032 cut_out stuck at 1, defaults -> signature != 8'h00, pass=0, done=1.
REQ-033 SETTLE=3, PAT_COUNT=4 -> each pattern held 3 cycles before capture; done after 1+4*4+1=18 cycles; pat_idx=4.
REQ-034 rst asserted at pattern 7 of a run -> next cycle IDLE, all outputs at reset values; a new start reproduces the REQ-031 result.
REQ-035 start pulsed while busy=1 -> no effect; run completes normally. start held high -> back-to-back runs with identical signatures.
REQ-036 BIST_EXHAUSTIVE_EN defined -> cut_in runs 0000..1111; pat_idx=16; fault-free pass=1.
